// File: rtl/ws2812_receiver.sv
// WS2812 single-wire NRZ decoder: recovers 24-bit pixel words and frame boundaries.
// Define WS2812_RX_FORWARD_EN to add the dout daisy-chain pass-through output.
module ws2812_receiver #(
  parameter int unsigned BIT_THRESH   = 26,
  parameter int unsigned MIN_HIGH     = 5,
  parameter int unsigned MAX_HIGH     = 50,
  parameter int unsigned RESET_CYCLES = 2500,
  parameter int unsigned MAX_PIXELS   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        din_i,
  output logic [23:0] pixel_data_o,
  output logic        pixel_valid_o,
  output logic [15:0] pixel_idx_o,
  output logic        frame_done_o,
  output logic [15:0] frame_pixels_o,
  output logic        err_o,
`ifdef WS2812_RX_FORWARD_EN
  output logic        dout_o,
`endif
  output logic        busy_o
);

  localparam int unsigned HW = $clog2(MAX_HIGH + 2);
  localparam int unsigned LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] HighOne = HW'(1);
  localparam logic [HW-1:0] HighMin = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HighMax = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HighThr = HW'(BIT_THRESH);
  localparam logic [LW-1:0] LowOne  = LW'(1);
  localparam logic [LW-1:0] LowEnd  = LW'(RESET_CYCLES);
  localparam logic [15:0]   PixMax  = 16'(MAX_PIXELS - 1);

  localparam logic [1:0] StSync = 2'd0;
  localparam logic [1:0] StIdle = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StLow  = 2'd3;

  logic          din_s1_q, din_s2_q, din_h_q;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] high_cnt_q, high_cnt_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic [22:0]   shift_q, shift_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          got_bit_q, got_bit_d;
  logic          busy_q, busy_d;
  logic [23:0]   pixel_data_q, pixel_data_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [15:0]   pixel_idx_q, pixel_idx_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_pixels_q, frame_pixels_d;
  logic          err_q, err_d;
  logic          rise, fall;
  logic [23:0]   shift_in;

  assign rise = din_s2_q & ~din_h_q;
  assign fall = ~din_s2_q & din_h_q;

  always_comb begin
    state_d        = state_q;
    high_cnt_d     = high_cnt_q;
    low_cnt_d      = low_cnt_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    word_cnt_d     = word_cnt_q;
    got_bit_d      = got_bit_q;
    busy_d         = busy_q;
    pixel_data_d   = pixel_data_q;
    pixel_valid_d  = 1'b0;
    pixel_idx_d    = pixel_idx_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_d          = 1'b0;
    shift_in       = {shift_q, (high_cnt_q >= HighThr)};

    case (state_q)
      StSync: begin
        if (din_s2_q) begin
          low_cnt_d = '0;
        end else if (low_cnt_q == LowEnd - LowOne) begin
          state_d   = StIdle;
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_cnt_q + LowOne;
        end
      end
      StIdle: begin
        if (rise) begin
          state_d    = StHigh;
          high_cnt_d = HighOne;
          busy_d     = 1'b1;
        end
      end
      StHigh: begin
        if (fall) begin
          if (high_cnt_q < HighMin) begin
            err_d = 1'b1;
          end else begin
            shift_d   = shift_in[22:0];
            got_bit_d = 1'b1;
            if (bit_cnt_q == 5'd23) begin
              pixel_data_d  = shift_in;
              pixel_valid_d = 1'b1;
              pixel_idx_d   = word_cnt_q;
              bit_cnt_d     = '0;
              if (word_cnt_q != PixMax) word_cnt_d = word_cnt_q + 16'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
          state_d   = StLow;
          low_cnt_d = LowOne;
        end else if (high_cnt_q >= HighMax) begin
          // Overlong high: we may be mid-frame of an unknown stream, so resync.
          err_d      = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          got_bit_d  = 1'b0;
          busy_d     = 1'b0;
          low_cnt_d  = '0;
          state_d    = StSync;
        end else begin
          high_cnt_d = high_cnt_q + HighOne;
        end
      end
      StLow: begin
        if (rise) begin
          state_d    = StHigh;
          high_cnt_d = HighOne;
        end else if (low_cnt_q == LowEnd - LowOne) begin
          frame_done_d = got_bit_q;
          if (got_bit_q) frame_pixels_d = word_cnt_q;
          err_d      = (bit_cnt_q != 5'd0);
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          got_bit_d  = 1'b0;
          busy_d     = 1'b0;
          low_cnt_d  = '0;
          state_d    = StIdle;
        end else begin
          low_cnt_d = low_cnt_q + LowOne;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      din_s1_q       <= 1'b0;
      din_s2_q       <= 1'b0;
      din_h_q        <= 1'b0;
      state_q        <= StSync;
      high_cnt_q     <= '0;
      low_cnt_q      <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      got_bit_q      <= 1'b0;
      busy_q         <= 1'b0;
      pixel_data_q   <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_idx_q    <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= 1'b0;
    end else begin
      din_s1_q       <= din_i;
      din_s2_q       <= din_s1_q;
      din_h_q        <= din_s2_q;
      state_q        <= state_d;
      high_cnt_q     <= high_cnt_d;
      low_cnt_q      <= low_cnt_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      word_cnt_q     <= word_cnt_d;
      got_bit_q      <= got_bit_d;
      busy_q         <= busy_d;
      pixel_data_q   <= pixel_data_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_idx_q    <= pixel_idx_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_q          <= err_d;
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  logic fwd_en_q, fwd_en_d;
  logic dout_q, dout_d;

  // Pass-through opens after the first word and closes whenever the FSM leaves the frame.
  always_comb begin
    fwd_en_d = fwd_en_q;
    if (pixel_valid_d) fwd_en_d = 1'b1;
    if (state_d == StIdle || state_d == StSync) fwd_en_d = 1'b0;
    dout_d = fwd_en_d & din_s2_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_en_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      fwd_en_q <= fwd_en_d;
      dout_q   <= dout_d;
    end
  end

  assign dout_o = dout_q;
`endif

  assign pixel_data_o   = pixel_data_q;
  assign pixel_valid_o  = pixel_valid_q;
  assign pixel_idx_o    = pixel_idx_q;
  assign frame_done_o   = frame_done_q;
  assign frame_pixels_o = frame_pixels_q;
  assign err_o          = err_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_ws2812_receiver.sv
// Scoreboard bench for ws2812_receiver: pulse-level reference model feeds expected
// pixels/frames into queues; a negedge monitor pops and compares on each DUT strobe.
module tb_ws2812_receiver;

  localparam int MinHigh     = 5;
  localparam int MaxHigh     = 50;
  localparam int BitThresh   = 26;
  localparam int ResetCycles = 2500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [15:0] pixel_idx;
  logic        frame_done;
  logic [15:0] frame_pixels;
  logic        err;
  logic        busy;
`ifdef WS2812_RX_FORWARD_EN
  logic        dout;
`endif

  ws2812_receiver dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .din_i          (din),
    .pixel_data_o   (pixel_data),
    .pixel_valid_o  (pixel_valid),
    .pixel_idx_o    (pixel_idx),
    .frame_done_o   (frame_done),
    .frame_pixels_o (frame_pixels),
    .err_o          (err),
`ifdef WS2812_RX_FORWARD_EN
    .dout_o         (dout),
`endif
    .busy_o         (busy)
  );

  always #10 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_err = 0;
  int obs_err = 0;

  logic [39:0] exp_pix[$];  // {idx, data}
  logic [16:0] exp_frm[$];  // {pixel count, partial-word err}

  // Reference model state: what the line has carried so far, in protocol terms.
  bit          m_synced = 1'b0;
  logic [23:0] m_word   = '0;
  int          m_nbits  = 0;
  int          m_nwords = 0;
  bit          m_got    = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic model_high(input int h);
    if (!m_synced) return;
    if (h > MaxHigh) begin
      exp_err++;
      m_synced = 1'b0;
      m_nbits  = 0;
      m_nwords = 0;
      m_got    = 1'b0;
    end else if (h < MinHigh) begin
      exp_err++;
    end else begin
      m_word  = {m_word[22:0], (h >= BitThresh)};
      m_nbits = m_nbits + 1;
      m_got   = 1'b1;
      if (m_nbits == 24) begin
        exp_pix.push_back({16'(m_nwords), m_word});
        m_nwords = m_nwords + 1;
        m_nbits  = 0;
      end
    end
  endtask

  task automatic model_low(input int l);
    if (l < ResetCycles) return;
    if (!m_synced) begin
      m_synced = 1'b1;
    end else begin
      if (m_got) exp_frm.push_back({16'(m_nwords), (m_nbits != 0)});
      if (m_nbits != 0) exp_err++;
      m_nbits  = 0;
      m_nwords = 0;
      m_got    = 1'b0;
    end
  endtask

  // Called aligned 1 time unit after a posedge; leaves the same alignment.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int l);
    model_high(h);
    model_low(l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic gap(input int l);
    model_low(l);
    hold(1'b0, l);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n, input int h1, input int l1,
                           input int h0, input int l0);
    for (int i = n - 1; i >= 0; i--) begin
      if (v[i]) drive(h1, l1);
      else      drive(h0, l0);
    end
  endtask

  task automatic send_rand_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if ($urandom_range(15, 0) == 0) drive(int'($urandom_range(4, 1)), 15);
      if (v[i]) drive(int'($urandom_range(50, BitThresh)), int'($urandom_range(40, 10)));
      else      drive(int'($urandom_range(BitThresh - 1, 8)), int'($urandom_range(40, 10)));
    end
  endtask

  // Monitor: decoupled from stimulus, compares whatever the DUT strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid) begin
        if (exp_pix.size() == 0) begin
          check("pixel_unexpected", {pixel_idx, pixel_data}, 40'hFF_FFFF_FFFF);
        end else begin
          check("pixel", {pixel_idx, pixel_data}, exp_pix.pop_front());
        end
      end
      if (frame_done) begin
        if (exp_frm.size() == 0) begin
          check("frame_unexpected", {frame_pixels, err}, 17'h1FFFF);
        end else begin
          check("frame", {frame_pixels, err}, exp_frm.pop_front());
        end
      end
      if (err) obs_err++;
`ifdef WS2812_RX_FORWARD_EN
      if (!busy && dout) check("dout_idle", dout, 1'b0);
`endif
    end
  end

  initial begin
    #(20 * 98000);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    repeat (3) @(negedge clk);
    check("rst_pixel_data", pixel_data, 24'h0);
    check("rst_pixel_valid", pixel_valid, 1'b0);
    check("rst_pixel_idx", pixel_idx, 16'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_pixels", frame_pixels, 16'h0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    gap(2600);

    // Single known word with nominal timing.
    send_bits(24'hA5C3F0, 24, 35, 28, 17, 46);
    check("busy_in_frame", busy, 1'b1);
    gap(5000);
    check("busy_after_frame", busy, 1'b0);

    // Eight back-to-back words.
    for (int i = 1; i <= 8; i++) send_bits(24'(i), 24, 35, 28, 17, 46);
    gap(3000);

    // Threshold boundary: 26 cycles decodes as 1, 25 as 0.
    send_bits(24'h5A3C96, 24, 26, 40, 25, 40);
    gap(3000);

    // Short glitch between bits: err, word still decodes.
    w = 24'($urandom);
    send_bits({12'h0, w[23:12]}, 12, 35, 28, 17, 46);
    drive(3, 30);
    send_bits({12'h0, w[11:0]}, 12, 35, 28, 17, 46);
    gap(3000);

    // Overlong high mid-word, then traffic that must be ignored until a full reset gap.
    send_bits(24'($urandom), 10, 35, 28, 17, 46);
    drive(60, 500);
    send_bits(24'($urandom), 24, 35, 28, 17, 46);
    gap(3000);
    send_bits(24'($urandom), 24, 35, 28, 17, 46);
    gap(3000);

    // 30 bits: one word plus a partial word at frame end.
    send_bits(24'($urandom), 24, 35, 28, 17, 46);
    send_bits(24'($urandom), 6, 35, 28, 17, 46);
    gap(3000);

    // Randomized frames with jittered timing, glitches and partial tails.
    for (int f = 0; f < 5; f++) begin
      int nw;
      nw = int'($urandom_range(2, 1));
      for (int k = 0; k < nw; k++) send_rand_bits(24'($urandom), 24);
      if ($urandom_range(2, 0) == 0) send_rand_bits(24'($urandom), int'($urandom_range(5, 1)));
      gap(int'($urandom_range(3000, 2700)));
    end

    repeat (20) @(negedge clk);
    check("pixels_outstanding", 64'(exp_pix.size()), 64'd0);
    check("frames_outstanding", 64'(exp_frm.size()), 64'd0);
    check("err_strobe_count", 64'(obs_err), 64'(exp_err));
    check("busy_end", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ws2812_receiver.md
Name: ws2812_receiver

Overview:
- Decodes a WS2812 single-wire serial stream (800 kHz NRZ pulse-width coding) back into 24-bit pixel words, running on the 50 MHz system clock.
- Sits at the far end of an LED chain, or on a loopback tap in test fixtures, to check what the LED transmitter actually sends.
- Emits one strobe per decoded pixel and one strobe per frame.
- Detects the >=50 us low reset gap as the frame delimiter and flags malformed pulses.

Parameters:
- BIT_THRESH, 26: high-pulse width in clk cycles at or above which a bit decodes as 1 (midpoint of 17 and 35).
- MIN_HIGH, 5: high pulses shorter than this are glitches.
- MAX_HIGH, 50: high pulses longer than this are protocol errors.
- RESET_CYCLES, 2500: low time in cycles (50 us) that ends a frame.
- MAX_PIXELS, 1024: per-frame pixel counter saturates at MAX_PIXELS-1 for pixel_idx.

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- din  in  1  WS2812 serial line, asynchronous to clk
- pixel_data  out  24  last decoded word; first received bit lands in bit 23
- pixel_valid  out  1  one-cycle strobe, pixel_data updated this cycle
- pixel_idx  out  16  index within the frame of the word on pixel_data (0-based)
- frame_done  out  1  one-cycle strobe at reset-gap detection after at least one bit
- frame_pixels  out  16  count of complete words in the frame just ended; valid with frame_done
- err  out  1  one-cycle strobe on glitch, overlong high, or partial word at frame end
- busy  out  1  high from the first rising edge of a frame until frame_done or error resync

Behaviour:
- Reset values: all outputs 0, FSM in SYNC, all counters 0, synchronizer flops 0.
- din passes through a 2-flop synchronizer. Edge detection uses the synced value plus one history flop, so decode latency is 3 cycles from the pin.
- States:
  - SYNC: line must be continuously low for RESET_CYCLES before any decoding. A high resets the low counter. Reaching RESET_CYCLES goes to IDLE with no frame_done. Entered after reset and after any overlong-high error, so decoding never starts mid-frame.
  - IDLE: wait for rising edge -> HIGH; high_cnt=1; busy=1.
  - HIGH: high_cnt increments each cycle, saturating at MAX_HIGH+1.
    - If high_cnt exceeds MAX_HIGH: err strobe, discard partial word, busy=0, -> SYNC.
    - On falling edge with high_cnt < MIN_HIGH: err strobe, bit dropped, -> LOW.
    - On falling edge otherwise: bit = (high_cnt >= BIT_THRESH), shifted in MSB-first, bit_cnt+1, -> LOW with low_cnt=1.
  - LOW: low_cnt increments, saturating at RESET_CYCLES.
    - Rising edge -> HIGH, high_cnt=1.
    - low_cnt reaching RESET_CYCLES ends the frame: frame_done=1 and frame_pixels=word count (if any bit or word was received this frame). If bit_cnt != 0, err also pulses in the same cycle and the partial word is discarded. Then clear bit_cnt and word count, busy=0, -> IDLE.
- Word completion: the cycle the 24th bit is shifted in, pixel_data takes the full word, pixel_valid=1, pixel_idx=current word count, the word count increments (saturating), and bit_cnt returns to 0. pixel_data holds its value until the next word.
- Low time between bits is not checked beyond the reset threshold; bit period jitter is tolerated.
- A falling edge and a completed word never collide with frame end: the 24th bit completes in HIGH->LOW, and frame end only occurs in LOW.
- Asserting reset mid-frame clears everything immediately. No frame_done or pixel_valid is emitted for the interrupted frame. The block resyncs via SYNC.

Optional Feature:
- Macro WS2812_RX_FORWARD_EN adds output port dout (1 bit): daisy-chain pass-through in the manner of a WS2812 pixel.
- With the macro: dout=0 until the first word of a frame completes. It then follows the synchronized din, delayed by the same 3 cycles, for the rest of the frame. It is forced to 0 in SYNC, IDLE, and at frame end. Reset value is 0.
- Without the macro: no dout port and no gating logic. All other behaviour is identical.

Test Plan:
- After reset, hold din low 2500 cycles, then send 24 bits of 0xA5C3F0 (1 = 35 high/28 low, 0 = 17 high/46 low), then 5000 low -> pixel_valid once, pixel_data=0xA5C3F0, pixel_idx=0; frame_done with frame_pixels=1; err never.
- Send 8 words 0x000001..0x000008 back-to-back, then the reset gap -> 8 pixel_valid strobes, idx 0..7, matching data; frame_pixels=8. The output of the team's ws2812 transmitter with LED_COUNT=8 is an acceptable stimulus.
- Widths at the boundaries: high pulses of 25 and 26 cycles -> decoded 0 and 1 respectively.
- Insert a 3-cycle high glitch between bits -> err strobe, word still decodes correctly from the remaining 24 valid bits.
- Hold din high 60 cycles mid-word -> err; no pixel_valid; the next frame is decoded only after 2500 low cycles.
- Send 30 bits, then the reset gap -> one pixel_valid (first 24 bits), then frame_done with frame_pixels=1 and err in the same cycle. With WS2812_RX_FORWARD_EN, dout stays 0 during the first 24 bits and mirrors bits 25-30 delayed by 3 cycles.
